// File: rtl/ballot_collector_pkg.sv
// ballot_collector_pkg: FSM state encoding and ballot-bus slot helper shared by the collector.
package ballot_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    function automatic int slot_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ballot_collector_count.sv
// ballot_collector_count: population count of a W-bit vector.
module ballot_collector_count #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++)
            cnt = cnt + CW'(bits[i]);
    end

endmodule

// File: rtl/ballot_collector_decoder.sv
// ballot_collector_decoder: binary index to one-hot decoder.
module ballot_collector_decoder #(
    parameter int N = 2
) (
    input  logic [N-1:0]    idx,
    output logic [2**N-1:0] onehot
);

    assign onehot = {{(2**N-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: gathers one ballot per voter into a bus for the tally stage.
// BALLOT_DUP_REJECT_EN: keep first ballot per voter and pulse dup_err; otherwise last ballot wins.
module ballot_collector
    import ballot_collector_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M-1:0]      in_voter,
    input  logic [N-1:0]      in_cand,
    input  logic              clear,
    output logic [(2**M)*N-1:0] vote,
    output logic              vote_valid,
    input  logic              vote_ack,
    output logic [M:0]        filled,
    output logic              dup_err
);

    localparam int V = 2**M;

    state_t         state;
    logic [V-1:0]   fmap;
    logic [V-1:0]   hot;
    logic [V-1:0]   nxt_map;
    logic           accept;
    logic           dup;
    logic           store;

    ballot_collector_decoder #(.N(M)) u_dec (
        .idx    (in_voter),
        .onehot (hot)
    );

    ballot_collector_count #(.W(V), .CW(M + 1)) u_cnt (
        .bits (fmap),
        .cnt  (filled)
    );

    assign in_ready   = state == COLLECT;
    assign vote_valid = state == FULL;
    assign accept     = in_valid && in_ready;
    assign dup        = |(fmap & hot);
    assign nxt_map    = fmap | hot;

`ifdef BALLOT_DUP_REJECT_EN
    logic dup_q;
    assign dup_err = dup_q;
    assign store   = accept && !dup;
`else
    assign dup_err = 1'b0;
    assign store   = accept;
`endif

    // clear outranks both acceptance and vote_ack, so a coincident ballot is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            fmap  <= '0;
            vote  <= '0;
`ifdef BALLOT_DUP_REJECT_EN
            dup_q <= 1'b0;
`endif
        end else if (clear || (state == FULL && vote_ack)) begin
            state <= COLLECT;
            fmap  <= '0;
            vote  <= '0;
`ifdef BALLOT_DUP_REJECT_EN
            dup_q <= 1'b0;
`endif
        end else begin
`ifdef BALLOT_DUP_REJECT_EN
            dup_q <= accept && dup;
`endif
            if (store)
                vote[slot_lo(int'(in_voter), N) +: N] <= in_cand;
            if (accept) begin
                fmap <= nxt_map;
                if (&nxt_map)
                    state <= FULL;
            end
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector: randomized and directed checks against a set-based ballot-box model.
module tb_ballot_collector;

    localparam int N = 2;
    localparam int M = 2;
    localparam int V = 4;
`ifdef BALLOT_DUP_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   in_voter;
    logic [N-1:0]   in_cand;
    logic           clear;
    logic [V*N-1:0] vote;
    logic           vote_valid;
    logic           vote_ack;
    logic [M:0]     filled;
    logic           dup_err;

    int checks = 0;
    int errors = 0;

    bit seen [V];
    int slot [V];
    bit full;
    bit exp_dup;

    always #5 clk = ~clk;

    ballot_collector #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_voter   (in_voter),
        .in_cand    (in_cand),
        .clear      (clear),
        .vote       (vote),
        .vote_valid (vote_valid),
        .vote_ack   (vote_ack),
        .filled     (filled),
        .dup_err    (dup_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_vote();
        int s = 0;
        for (int i = 0; i < V; i++) s += slot[i] * (1 << (N * i));
        return s;
    endfunction

    function automatic int exp_filled();
        int s = 0;
        for (int i = 0; i < V; i++) s += int'(seen[i]);
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < V; i++) begin
            seen[i] = 1'b0;
            slot[i] = 0;
        end
        full    = 1'b0;
        exp_dup = 1'b0;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".vote"},       32'(vote),       32'(exp_vote()));
        check({ph, ".vote_valid"}, 32'(vote_valid), 32'(full));
        check({ph, ".filled"},     32'(filled),     32'(exp_filled()));
        check({ph, ".in_ready"},   32'(in_ready),   32'(!full));
        check({ph, ".dup_err"},    32'(dup_err),    32'(exp_dup));
    endtask

    // predicts the state after the coming rising edge from the ballot-box rules
    task automatic predict(input bit v, input int vo, input int c, input bit clr, input bit ack);
        if (clr) model_clear();
        else if (full) begin
            exp_dup = 1'b0;
            if (ack) model_clear();
        end else begin
            exp_dup = 1'b0;
            if (v) begin
                if (seen[vo]) begin
                    exp_dup = REJ;
                    if (!REJ) slot[vo] = c;
                end else begin
                    seen[vo] = 1'b1;
                    slot[vo] = c;
                end
                if (exp_filled() == V) full = 1'b1;
            end
        end
    endtask

    task automatic step(input string ph, input bit v, input int vo, input int c, input bit clr, input bit ack);
        check_all(ph);
        in_valid = v;
        in_voter = M'(vo);
        in_cand  = N'(c);
        clear    = clr;
        vote_ack = ack;
        predict(v, vo, c, clr, ack);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    int order [4] = '{3, 0, 2, 1};
    int k;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_voter = '0; in_cand = '0; clear = 1'b0; vote_ack = 1'b0;
        model_clear();
        #3 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("r36a", 1, 0, 3, 0, 0);
        step("r36b", 1, 1, 1, 0, 0);
        step("r36c", 1, 2, 1, 0, 0);
        step("r36d", 1, 3, 0, 0, 0);
        check("r36.vote_const", 32'(vote), 32'h17);
        check("r36.filled_const", 32'(filled), 32'd4);
        for (int i = 0; i < 5; i++) step("r37hold", 1, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        step("r37ack", 0, 0, 0, 0, 1);
        step("r37post", 0, 0, 0, 0, 1);
        step("r38a", 1, 1, 2, 0, 0);
        step("r38b", 1, 1, 3, 0, 0);
        step("r38c", 0, 0, 0, 0, 0);
        check("r38.slot1", 32'(vote[3:2]), REJ ? 32'd2 : 32'd3);
        check("r38.filled", 32'(filled), 32'd1);
        step("r39clr0", 0, 0, 0, 1, 0);
        step("r39a", 1, 0, 1, 0, 0);
        step("r39b", 1, 1, 2, 0, 0);
        step("r39c", 1, 2, 3, 0, 0);
        step("r39d", 1, 3, 1, 1, 0);
        idle("r39idle", 2);
        step("r40a", 1, 0, 2, 0, 0);
        step("r40b", 1, 1, 3, 0, 0);
        check_all("r40pre");
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_all("r40async");
        @(negedge clk);
        check_all("r40held");
        rst_n = 1'b1;
        step("r40c", 1, 2, 1, 0, 0);
        step("r40d", 1, 3, 2, 0, 0);
        step("r40e", 1, 0, 3, 0, 0);
        step("r40f", 1, 1, 0, 0, 0);
        step("r40ack", 0, 0, 0, 0, 1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            bit v = 1'($urandom_range(0, 1));
            step("r41", v, order[k % 4], $urandom_range(0, 3), 0, 0);
            if (v) k++;
        end
        step("r41ack", 0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
        check_all("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ballot_collector.md
BALLOT_COLLECTOR -- requirements
Module: ballot_collector

Interface
- REQ-001: Parameter N, default 2, candidate-index width; there are 2**N candidates.
- REQ-002: Parameter M, default 2, voter-index width; there are 2**M voters.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: in_valid  input  1  a ballot is present on in_voter/in_cand.
- REQ-006: in_ready  output  1  collector can accept a ballot this cycle.
- REQ-007: in_voter  input  M  voter index of the offered ballot.
- REQ-008: in_cand  input  N  candidate index of the offered ballot.
- REQ-009: clear  input  1  synchronous abort; empties the collector.
- REQ-010: vote  output  (2**M)*N  assembled ballot bus; slot i at bits [(i+1)*N-1:i*N]; feeds the tally stage directly.
- REQ-011: vote_valid  output  1  all 2**M slots are filled and vote is stable.
- REQ-012: vote_ack  input  1  downstream has consumed vote.
- REQ-013: filled  output  M+1  number of distinct voters recorded.
- REQ-014: dup_err  output  1  one-cycle pulse flagging a duplicate ballot.

Function
- REQ-015: The FSM shall have two states, COLLECT and FULL.
- REQ-016: in_ready shall be 1 only in COLLECT.
- REQ-017: A ballot is accepted on a cycle with in_valid=1 and in_ready=1. An accepted ballot shall write in_cand into slot in_voter and set that voter's bit in a 2**M-bit filled-map.
- REQ-018: filled shall equal the popcount of the filled-map. It shall update on the edge after acceptance.
- REQ-019: On the edge where the filled-map becomes all ones, the FSM shall move to FULL. vote_valid shall be 1 from the next cycle.
- REQ-020: In FULL, vote and filled shall hold. in_valid shall be ignored and dup_err shall stay 0.
- REQ-021: In FULL, vote_ack=1 shall clear vote, the filled-map and filled to 0 and return the FSM to COLLECT. in_ready shall be 1 the following cycle.
- REQ-022: vote_ack in COLLECT shall have no effect.
- REQ-023: clear=1 in any state shall perform the same clearing as REQ-021 and enter COLLECT.
- REQ-024: clear shall take priority over a simultaneous acceptance or vote_ack; the ballot is dropped.
- REQ-025: Duplicate-ballot handling (acceptance for a voter whose bit is already set) is defined in Configuration.
- REQ-026: The latency from the final acceptance to vote_valid shall be exactly 1 cycle.

Reset
- REQ-027: While rst_n=0, independent of clk, the FSM shall be in COLLECT and the filled-map shall be 0.
- REQ-028: While rst_n=0, the outputs shall be: vote=0, vote_valid=0, filled=0, dup_err=0, in_ready=1.
- REQ-029: A reset asserted mid-collection or in FULL shall discard all ballots.
- REQ-030: The first acceptance shall be possible on the first rising edge after rst_n deasserts.

Configuration
- REQ-031: Macro BALLOT_DUP_REJECT_EN defined: a duplicate ballot is accepted (handshake completes) but not stored. The slot keeps its first value, and dup_err pulses 1 on the next cycle.
- REQ-032: Macro BALLOT_DUP_REJECT_EN undefined: a duplicate ballot overwrites its slot (last vote wins), filled is unchanged, and dup_err is tied to 0.

Structure
- REQ-033: A shared package shall hold the FSM state encoding (COLLECT=0, FULL=1) and the slot-offset helper constant.
- REQ-034: Voter-index one-hot generation shall reuse the existing decoder sub-module (parameter N set to M).
- REQ-035: The popcount for filled shall reuse the existing COUNT sub-module.

Verification (N=2, M=2)
- REQ-036: Reset, then ballots (v0,c3),(v1,c1),(v2,c1),(v3,c0) on consecutive cycles -> vote=8'b00_01_01_11 and vote_valid=1 one cycle after the 4th; filled=4.
- REQ-037: Full, vote_ack held 0 for 5 cycles with in_valid=1 -> vote unchanged, in_ready=0, dup_err=0; ack -> next cycle filled=0, in_ready=1, vote=0.
- REQ-038: Ballots (v1,c2) then (v1,c3) -> with BALLOT_DUP_REJECT_EN: slot1=2, dup_err pulses once, filled=1; without: slot1=3, dup_err=0, filled=1.
- REQ-039: Three ballots, then clear coincident with a 4th valid ballot -> filled=0, vote=0, vote_valid never asserts.
- REQ-040: rst_n pulsed low mid-cycle after 2 ballots -> outputs go to reset values immediately, without waiting for a clk edge; a fresh 4-ballot sequence then completes normally.
- REQ-041: in_valid toggled randomly over 20 ballots in arrival order v3,v0,v2,v1 -> vote_valid only after all 4 distinct voters have been accepted.
